// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   md_state_e : encodings of the multiply/divide sequencer states
//   CNT_W      : width of the multiply/divide busy-cycle counter
package hazard_ctrl_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/hazard_ctrl_md_sequencer.sv
// Multiply/divide unit sequencer: IDLE -> BUSY (N cycles) -> DONE (1 cycle).
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   start_i        : a mult/div is in EX this cycle (ignored while BUSY)
//   div_i          : qualifies start_i, 1 = divide, 0 = multiply
//   busy_o         : unit is in BUSY
//   done_o         : one-cycle strobe in DONE, HI/LO written this cycle
//   state_o        : current FSM state, for observation
module hazard_ctrl_md_sequencer
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      start_i,
  input  logic      div_i,
  output logic      busy_o,
  output logic      done_o,
  output md_state_e state_o
);

  // Counter holds the number of BUSY cycles still to go after this one.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      // DONE accepts a new start directly, so back-to-back ops have no idle gap.
      MD_IDLE, MD_DONE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = div_i ? DIV_LOAD : MUL_LOAD;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = MD_DONE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o  = (state_q == MD_BUSY);
  assign done_o  = (state_q == MD_DONE);
  assign state_o = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller at the ID/EX boundary of the five-stage core.
// Detects load-use hazards and accesses to a busy multiply/divide unit,
// stalls the front end, flushes IF/ID on taken branches, and counts stall
// cycles (saturating).
// Ports:
//   clk_i, rst_n_i       : clock, asynchronous active-low reset
//   id_rs_i, id_rt_i     : source registers of the ID instruction
//   id_use_rs_i/_rt_i    : ID instruction actually reads rs / rt
//   ex_memread_i, ex_rt_i: EX instruction is a load, and its destination
//   id_branch_taken_i    : branch in ID resolved taken
//   id_md_start_i        : ID instruction is mult/div
//   id_md_read_i         : ID instruction is mfhi/mflo
//   ex_md_start_i        : mult/div in EX this cycle, ex_md_div_i selects div
//   pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o : pipeline controls
//   md_busy_o, md_done_o : multiply/divide unit status
//   stall_cnt_o          : saturating stall-cycle counter
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_use_rs_i,
  input  logic        id_use_rt_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        id_branch_taken_i,
  input  logic        id_md_start_i,
  input  logic        id_md_read_i,
  input  logic        ex_md_start_i,
  input  logic        ex_md_div_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        md_busy_o,
  output logic        md_done_o,
  output logic [15:0] stall_cnt_o
);

  md_state_e   md_state;
  logic        load_use;
  logic        md_stall;
  logic        stall;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  hazard_ctrl_md_sequencer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_seq (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (ex_md_start_i),
    .div_i   (ex_md_div_i),
    .busy_o  (md_busy_o),
    .done_o  (md_done_o),
    .state_o (md_state)
  );

  always_comb begin
    // $zero is never a real dependency.
    load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
               ((id_use_rs_i && (id_rs_i == ex_rt_i)) ||
                (id_use_rt_i && (id_rt_i == ex_rt_i)));
    // No stall in DONE: HI/LO land at the end of that cycle, in time for ID.
    md_stall = (id_md_start_i || id_md_read_i) &&
               ((md_state == MD_BUSY) || ex_md_start_i);
    stall    = load_use || md_stall;

    pc_write_o    = !stall;
    ifid_write_o  = !stall;
    idex_bubble_o = stall;
    // A stalled branch stays in ID and flushes once the stall clears.
    ifid_flush_o  = id_branch_taken_i && !stall;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with default MUL_CYCLES = 4, DIV_CYCLES = 32.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_use_rs = 0, id_use_rt = 0, ex_memread = 0, id_branch_taken = 0;
  logic        id_md_start = 0, id_md_read = 0, ex_md_start = 0, ex_md_div = 0;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done;
  logic [15:0] stall_cnt;

  int total = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int done_pulses;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .id_use_rs_i       (id_use_rs),
    .id_use_rt_i       (id_use_rt),
    .ex_memread_i      (ex_memread),
    .ex_rt_i           (ex_rt),
    .id_branch_taken_i (id_branch_taken),
    .id_md_start_i     (id_md_start),
    .id_md_read_i      (id_md_read),
    .ex_md_start_i     (ex_md_start),
    .ex_md_div_i       (ex_md_div),
    .pc_write_o        (pc_write),
    .ifid_write_o      (ifid_write),
    .ifid_flush_o      (ifid_flush),
    .idex_bubble_o     (idex_bubble),
    .md_busy_o         (md_busy),
    .md_done_o         (md_done),
    .stall_cnt_o       (stall_cnt)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; caller then sets inputs and waits #1.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_busy", 16'(md_busy), 16'd0);
    check("rst_done", 16'(md_done), 16'd0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_pc_write", 16'(pc_write), 16'd1);
    check("rst_ifid_write", 16'(ifid_write), 16'd1);
    check("rst_flush", 16'(ifid_flush), 16'd0);
    check("rst_bubble", 16'(idex_bubble), 16'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // Load-use: lw $8 in EX, add reading $8 in ID -> one stall cycle
    next_cycle();
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1;
    #1;
    check("lu_pc_write", 16'(pc_write), 16'd0);
    check("lu_ifid_write", 16'(ifid_write), 16'd0);
    check("lu_bubble", 16'(idex_bubble), 16'd1);
    next_cycle();
    ex_memread = 0; ex_rt = 5'd0;   // bubble now sits in EX
    #1;
    check("lu_after_pc_write", 16'(pc_write), 16'd1);
    check("lu_after_bubble", 16'(idex_bubble), 16'd0);
    check("lu_stall_cnt", stall_cnt, 16'd1);

    // Load into $zero: no dependency
    next_cycle();
    ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0; id_use_rs = 1;
    #1;
    check("lu_zero_pc_write", 16'(pc_write), 16'd1);
    check("lu_zero_bubble", 16'(idex_bubble), 16'd0);
    // rt match path, rs not used
    next_cycle();
    ex_rt = 5'd9; id_rs = 5'd9; id_use_rs = 0; id_rt = 5'd9; id_use_rt = 1;
    #1;
    check("lu_rt_bubble", 16'(idex_bubble), 16'd1);
    next_cycle();
    ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_use_rt = 0;
    #1;
    check("lu_rt_stall_cnt", stall_cnt, 16'd2);

    // Multiply latency, mfhi held in ID from T
    next_cycle();
    ex_md_start = 1; ex_md_div = 0; id_md_read = 1;
    #1;
    check("mul_T_busy", 16'(md_busy), 16'd0);
    check("mul_T_stall", 16'(pc_write), 16'd0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      ex_md_start = 0;
      #1;
      check("mul_busy", 16'(md_busy), 16'd1);
      check("mul_busy_done", 16'(md_done), 16'd0);
      check("mul_busy_stall", 16'(idex_bubble), 16'd1);
    end
    next_cycle();
    #1;
    check("mul_done", 16'(md_done), 16'd1);
    check("mul_done_busy", 16'(md_busy), 16'd0);
    check("mul_done_pc_write", 16'(pc_write), 16'd1);
    check("mul_stall_cnt", stall_cnt, 16'd7);
    next_cycle();
    id_md_read = 0;
    #1;
    check("mul_idle_done", 16'(md_done), 16'd0);
    check("mul_idle_busy", 16'(md_busy), 16'd0);

    // Branch taken together with load-use: flush deferred one cycle
    next_cycle();
    ex_memread = 1; ex_rt = 5'd3; id_rt = 5'd3; id_use_rt = 1; id_branch_taken = 1;
    #1;
    check("br_stall_flush", 16'(ifid_flush), 16'd0);
    next_cycle();
    ex_memread = 0; ex_rt = 0;
    #1;
    check("br_release_flush", 16'(ifid_flush), 16'd1);
    check("br_stall_cnt", stall_cnt, 16'd8);
    next_cycle();
    id_branch_taken = 0; id_rt = 0; id_use_rt = 0;

    // Back-to-back: div then mult started in DONE
    next_cycle();
    ex_md_start = 1; ex_md_div = 1;
    #1;
    done_pulses = 0;
    for (int i = 1; i <= 32; i++) begin
      next_cycle();
      ex_md_start = 0; ex_md_div = 0;
      #1;
      if (md_done) done_pulses++;
      if (i == 1 || i == 32) check("div_busy", 16'(md_busy), 16'd1);
    end
    next_cycle();
    ex_md_start = 1; ex_md_div = 0;
    #1;
    if (md_done) done_pulses++;
    check("b2b_div_done", 16'(md_done), 16'd1);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      ex_md_start = 0;
      #1;
      if (md_done) done_pulses++;
      check("b2b_mul_busy", 16'(md_busy), 16'd1);
    end
    next_cycle();
    #1;
    if (md_done) done_pulses++;
    check("b2b_mul_done", 16'(md_done), 16'd1);
    check("b2b_done_pulses", 16'(done_pulses), 16'd2);
    check("b2b_stall_cnt", stall_cnt, 16'd8);

    // Reset during divide at BUSY cycle 10, mfhi waiting in ID
    next_cycle();
    ex_md_start = 1; ex_md_div = 1; id_md_read = 1;
    #1;
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      ex_md_start = 0; ex_md_div = 0;
      #1;
    end
    check("rd_busy_before", 16'(md_busy), 16'd1);
    check("rd_stall_cnt_before", stall_cnt, 16'd18);
    rst_n = 1'b0;
    #1;
    check("rd_busy_reset", 16'(md_busy), 16'd0);
    check("rd_stall_cnt_reset", stall_cnt, 16'd0);
    id_md_read = 0;
    next_cycle();
    rst_n = 1'b1;
    done_pulses = 0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      #1;
      if (md_done || md_busy) done_pulses++;
    end
    check("rd_no_done_after", 16'(done_pulses), 16'd0);
    check("rd_idle_pc_write", 16'(pc_write), 16'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It sits beside the forwarding unit at the ID/EX boundary and detects the hazards forwarding cannot resolve: load-use dependencies, and accesses to a busy multi-cycle multiply/divide unit. It sequences that unit with a small FSM and counter, and drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MUL_CYCLES, default 4: BUSY cycles for a multiply; legal range 1..64.
- DIV_CYCLES, default 32: BUSY cycles for a divide; legal range 1..64.

Ports (clock and reset first):
- clk_i  in  1  core clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- id_rs_i  in  5  rs address of the instruction in ID.
- id_rt_i  in  5  rt address of the instruction in ID.
- id_use_rs_i  in  1  the ID instruction reads rs.
- id_use_rt_i  in  1  the ID instruction reads rt.
- ex_memread_i  in  1  the EX instruction is a load.
- ex_rt_i  in  5  destination register of the EX load.
- id_branch_taken_i  in  1  the branch in ID resolved taken.
- id_md_start_i  in  1  the ID instruction is mult/div.
- id_md_read_i  in  1  the ID instruction is mfhi/mflo.
- ex_md_start_i  in  1  a mult/div is in EX this cycle.
- ex_md_div_i  in  1  qualifies ex_md_start_i: 1 = div, 0 = mult.
- pc_write_o  out  1  PC write enable.
- ifid_write_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  zero the IF/ID register.
- idex_bubble_o  out  1  force ID/EX control fields to nop.
- md_busy_o  out  1  multiply/divide unit in BUSY.
- md_done_o  out  1  one-cycle strobe: write HI/LO this cycle.
- stall_cnt_o  out  16  saturating count of stall cycles.

## Operation
- load_use = ex_memread_i & (ex_rt_i != 0) & ((id_use_rs_i & id_rs_i == ex_rt_i) | (id_use_rt_i & id_rt_i == ex_rt_i)).
- MD FSM states: IDLE, BUSY, DONE. Counter cnt is 6 bits.
  - IDLE or DONE with ex_md_start_i: go to BUSY; cnt = (ex_md_div_i ? DIV_CYCLES : MUL_CYCLES) - 1.
  - IDLE or DONE without a start: go to IDLE.
  - BUSY with cnt != 0: decrement cnt, stay in BUSY. BUSY with cnt == 0: go to DONE.
  - ex_md_start_i is ignored while in BUSY; the stall rule below makes it unreachable.
- md_busy_o = (state == BUSY). md_done_o = (state == DONE).
- md_stall = (id_md_start_i | id_md_read_i) & ((state == BUSY) | ex_md_start_i). There is no stall in DONE, because HI/LO are written at the end of the DONE cycle.
- stall = load_use | md_stall. While stall: pc_write_o = 0, ifid_write_o = 0, idex_bubble_o = 1. Otherwise pc_write_o = 1, ifid_write_o = 1, idex_bubble_o = 0.
- ifid_flush_o = id_branch_taken_i & ~stall. A stalled branch is held in ID and flushes once the stall clears.
- stall_cnt_o increments on every clock edge where stall = 1 and holds at 16'hFFFF.
- Reset: state IDLE, cnt 0, stall_cnt_o 0, md_busy_o 0, md_done_o 0. With all inputs 0: pc_write_o 1, ifid_write_o 1, ifid_flush_o 0, idex_bubble_o 0.
- Reset asserted mid-operation aborts BUSY immediately. No md_done_o pulse follows.

## Timing
- Hazard outputs (pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o) are combinational from the inputs and the current state; there is no added latency.
- A start accepted in cycle T gives BUSY in cycles T+1 .. T+N and DONE in cycle T+N+1, where N is the selected cycle count.
- An mfhi in ID during cycles T .. T+N stalls N+1 cycles, and leaves ID during DONE.
- A start arriving in DONE re-enters BUSY at T+N+2. There is no idle gap.
- load_use and md_stall may coincide. They count as one stall cycle.

## Structure
- Shared header hazard_defs: state encodings (IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10) and CNT_W = 6.
- Sub-module md_sequencer: the FSM plus cnt. Inputs are start, div and cycle parameters. Outputs are busy and done.
- hazard_ctrl contains the load-use compare, stall/flush logic and stall_cnt_o.

## Test plan
- Load-use: EX lw with ex_rt_i = 8; ID add with rs = 8 and use_rs = 1. Required: exactly 1 cycle with pc_write_o = 0 and idex_bubble_o = 1; stall_cnt_o = 1. Repeat with ex_rt_i = 0: no stall.
- Multiply latency (MUL_CYCLES = 4): ex_md_start_i at T. Required: md_busy_o high T+1..T+4; md_done_o high only at T+5. mfhi held in ID from T stalls 5 cycles.
- Back-to-back: a div completes, and a mult's ex_md_start_i arrives in DONE. Required: md_done_o pulses once, then BUSY for 4 cycles with no IDLE cycle between.
- Branch versus stall: id_branch_taken_i = 1 together with load_use. Required: ifid_flush_o = 0 in that cycle, then ifid_flush_o = 1 in the next cycle.
- Reset mid-divide: assert rst_n_i = 0 at BUSY cycle 10. Required: md_busy_o = 0 and stall_cnt_o = 0 immediately. After release, the FSM is in IDLE and md_done_o is never asserted.
